// File: rtl/lock_pkg.sv
// Shared types and constants for the serial password lock.
//   lock_state_t : controller FSM states
//   DIGIT_W      : keypad digit width
//   DIGITS       : digits per password
//   ADMIN_CODE   : master code, used only when LOCK_ADMIN_CODE_EN is defined
package lock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DIGITS  = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t ADMIN_CODE [DIGITS] = '{4'h9, 4'h9, 4'h9, 4'h9};

  typedef enum logic [2:0] {
    StSet,
    StIdle,
    StCheck,
    StOpen,
    StAlarm
  } lock_state_t;

endpackage

// File: rtl/attempt_counter.sv
// Saturating 2-bit failed-attempt counter.
//   CLK, RST : clock, asynchronous active-high reset
//   inc      : count one failed attempt (saturates at 3)
//   clear    : return to zero, wins over inc
//   count    : current number of failed attempts
//   limit    : one more increment would make count reach MAX_FAILS
module attempt_counter #(
  parameter int unsigned MAX_FAILS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc,
  input  logic       clear,
  output logic [1:0] count,
  output logic       limit
);

  logic [1:0] count_q;
  logic [1:0] count_inc;

  assign count_inc = (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;

  // Looks ahead at the incremented value so the FSM can pick ALARM on the failing digit itself.
  assign limit = (32'(count_inc) >= MAX_FAILS);
  assign count = count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= 2'd0;
    end else if (clear) begin
      count_q <= 2'd0;
    end else if (inc) begin
      count_q <= count_inc;
    end
  end

endmodule

// File: rtl/lock_controller.sv
// Control FSM for the serial password lock. Programs a 4-digit password into the external
// 4x4-bit store, checks entered passwords against it, tracks failures and latches an alarm.
// Optional feature macro: LOCK_ADMIN_CODE_EN (admin code 9999 opens from IDLE/CHECK and
// clears ALARM).
//   CLK, RST   : clock, asynchronous active-high reset
//   digitIn    : keypad digit, qualified by the one-cycle strobe digitValid
//   cmdSet     : request password change (OPEN only)
//   cmdLock    : relock request (OPEN only, wins over cmdSet)
//   storeAddr  : store address, always the current digit index
//   storeWrite : store write enable (SET only)
//   storeWData : store write data
//   storeRData : store read data, combinational from storeAddr
//   unlocked, alarm, setting : registered state decodes
//   failCount  : failed attempts since last success
module lock_controller
  import lock_pkg::*;
#(
  parameter int unsigned MAX_FAILS = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DIGIT_W-1:0] digitIn,
  input  logic               digitValid,
  input  logic               cmdSet,
  input  logic               cmdLock,
  output logic [1:0]         storeAddr,
  output logic               storeWrite,
  output logic [DIGIT_W-1:0] storeWData,
  input  logic [DIGIT_W-1:0] storeRData,
  output logic               unlocked,
  output logic               alarm,
  output logic               setting,
  output logic [1:0]         failCount
);

  lock_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        mismatch_q, mismatch_d;
  logic        unlocked_q, alarm_q, setting_q;
  logic        fail_inc, fail_clr, fail_limit;
  logic        digit_ne;
  logic        pass;

  assign digit_ne = (digitIn != storeRData);

`ifdef LOCK_ADMIN_CODE_EN
  logic admin_mis_q, admin_mis_d;
  logic admin_ne;
  assign admin_ne = (digitIn != ADMIN_CODE[idx_q]);
  assign pass     = !(mismatch_q | digit_ne) || !(admin_mis_q | admin_ne);
`else
  assign pass     = !(mismatch_q | digit_ne);
`endif

  attempt_counter #(
    .MAX_FAILS(MAX_FAILS)
  ) u_attempt_counter (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (fail_inc),
    .clear(fail_clr),
    .count(failCount),
    .limit(fail_limit)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    fail_inc   = 1'b0;
    fail_clr   = 1'b0;
`ifdef LOCK_ADMIN_CODE_EN
    admin_mis_d = admin_mis_q;
`endif
    unique case (state_q)
      StSet: begin
        if (digitValid) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StIdle;
        end
      end
      StIdle: begin
        if (digitValid) begin
          mismatch_d = digit_ne;
`ifdef LOCK_ADMIN_CODE_EN
          admin_mis_d = admin_ne;
`endif
          idx_d      = 2'd1;
          state_d    = StCheck;
        end
      end
      StCheck: begin
        if (digitValid) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (pass) begin
              fail_clr = 1'b1;
              state_d  = StOpen;
            end else begin
              fail_inc = 1'b1;
              state_d  = fail_limit ? StAlarm : StIdle;
            end
          end else begin
            mismatch_d = mismatch_q | digit_ne;
`ifdef LOCK_ADMIN_CODE_EN
            admin_mis_d = admin_mis_q | admin_ne;
`endif
          end
        end
      end
      StOpen: begin
        if (cmdLock) begin
          state_d = StIdle;
          idx_d   = 2'd0;
        end else if (cmdSet) begin
          state_d = StSet;
          idx_d   = 2'd0;
        end
      end
      StAlarm: begin
`ifdef LOCK_ADMIN_CODE_EN
        if (digitValid) begin
          idx_d       = idx_q + 2'd1;
          // First digit of each group restarts the accumulated mismatch.
          admin_mis_d = ((idx_q == 2'd0) ? 1'b0 : admin_mis_q) | admin_ne;
          if ((idx_q == 2'd3) && !(admin_mis_q | admin_ne)) begin
            fail_clr = 1'b1;
            state_d  = StIdle;
          end
        end
`endif
      end
      default: begin
        state_d = StSet;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StSet;
      idx_q      <= 2'd0;
      mismatch_q <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      setting_q  <= 1'b1;
`ifdef LOCK_ADMIN_CODE_EN
      admin_mis_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      unlocked_q <= (state_d == StOpen);
      alarm_q    <= (state_d == StAlarm);
      setting_q  <= (state_d == StSet);
`ifdef LOCK_ADMIN_CODE_EN
      admin_mis_q <= admin_mis_d;
`endif
    end
  end

  assign storeAddr  = idx_q;
  assign storeWrite = (state_q == StSet) && digitValid;
  assign storeWData = storeWrite ? digitIn : '0;
  assign unlocked   = unlocked_q;
  assign alarm      = alarm_q;
  assign setting    = setting_q;

endmodule

// File: doc/lock_controller.md
# lock_controller

Control FSM for the serial password lock, directly upstream of the 4×4-bit password store. Accepts one 4-bit digit per strobe from the keypad front end. Drives the store's address, write-enable and write-data lines to program a new 4-digit password or to check an entered one against it. Tracks failed attempts and raises a latched alarm.

## Interface
- MAX_FAILS, default 3: failed check attempts that force ALARM (range 1..3).
- CLK  in  1  system clock, all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- digitIn  in  4  keypad digit, valid when digitValid=1.
- digitValid  in  1  one-cycle strobe, one digit per strobe.
- cmdSet  in  1  request password change (honoured only in OPEN).
- cmdLock  in  1  relock request (honoured only in OPEN).
- storeAddr  out  2  store address = current digit index.
- storeWrite  out  1  store write enable.
- storeWData  out  4  store write data.
- storeRData  in  4  store read data, combinational from storeAddr.
- unlocked  out  1  high in OPEN.
- alarm  out  1  high in ALARM.
- setting  out  1  high in SET.
- failCount  out  2  failed attempts since last success.

## Operation
- States: SET, IDLE, CHECK, OPEN, ALARM. Reset state is SET. Store contents are undefined after reset, so a password must be programmed first.
- Digit index `idx` is 2 bits. It is cleared on every state entry and increments on each accepted digit; the value after 3 is 0.
- SET:
  - storeWrite = digitValid, storeWData = digitIn, storeAddr = idx.
  - On the digit with idx=3, go to IDLE.
- IDLE: a digit with digitValid=1 is compared at address 0.
  - Sets the `mismatch` register to (digitIn != storeRData).
  - Goes to CHECK with idx=1.
- CHECK: each digit ORs its mismatch into `mismatch`. On the idx=3 digit the result is mismatch | (digitIn != storeRData):
  - Pass: go to OPEN and clear failCount.
  - Fail: failCount+1, saturating at 3. If the new value is ≥ MAX_FAILS, go to ALARM; otherwise go to IDLE.
- OPEN: digits are ignored. cmdLock goes to IDLE. cmdSet goes to SET. If both are high in the same cycle, cmdLock wins.
- ALARM: digits are ignored and it is left only via RST (see Configuration).
- storeWrite is 0 in every state except SET. storeAddr = idx in all states.
- cmdSet and cmdLock are ignored outside OPEN.

## Timing
- Reset values: state SET, idx 0, mismatch 0, failCount 0, storeWrite 0, storeWData 0, unlocked 0, alarm 0, setting 1.
- Write path: a digit strobed in SET is written to the store on the same CLK edge. The store sees address, enable and data in the strobe cycle.
- Compare path: combinational within the strobe cycle. Status outputs are registered state decodes, so the verdict is visible the cycle after the 4th strobe.
- Back-to-back strobes on consecutive cycles are fully supported. There is no busy or backpressure.
- RST asserted mid-sequence aborts it: the partial password stays in the store and the state returns to SET.

## Configuration
- LOCK_ADMIN_CODE_EN defined:
  - A parallel comparator checks entered digits against lock_pkg::ADMIN_CODE (digits 4'h9,4'h9,4'h9,4'h9).
  - A full admin match in IDLE/CHECK goes to OPEN regardless of the stored password.
  - In ALARM, digits are accepted (idx counts). An admin match clears failCount and goes to IDLE; any other 4 digits keep ALARM.
- Undefined: no admin path, and ALARM is exited only by RST.

## Structure
- lock_pkg holds:
  - the state enum `lock_state_t` (SET, IDLE, CHECK, OPEN, ALARM);
  - DIGIT_W=4, DIGITS=4, ADMIN_CODE (a 4-entry digit array).
- Sub-module `attempt_counter` is a saturating 2-bit fail counter with inc/clear inputs and a `limit` output compared against MAX_FAILS.
- The FSM, idx, mismatch and the admin comparator stay in lock_controller.

## Test plan
- Reset, then strobe 1,2,3,4 → storeWrite pulses at addr 0..3 with data 1..4; setting drops and the FSM is in IDLE.
- After programming 1,2,3,4, enter 1,2,3,4 → unlocked=1 the cycle after the 4th strobe, failCount=0.
- Enter 1,2,3,5 three times (MAX_FAILS=3) → failCount 1,2,3, alarm=1, further digits ignored, storeWrite stays 0.
- In OPEN, assert cmdSet and cmdLock together → IDLE, no writes. Then cmdSet alone in OPEN, digits 7,7,7,7 → store holds 7s, and a 7,7,7,7 check unlocks.
- RST after 2 digits of a check → setting=1, failCount=0, unlocked=0.
- With LOCK_ADMIN_CODE_EN in ALARM, enter 9,9,9,9 → IDLE, failCount=0. Without the macro, the same input leaves alarm=1.
